// File: rtl/bram_sdp_if.sv
// bram_sdp_if: user-side bus of the simple-dual-port RAM.
//   init_busy : clear sequencer running (RAM -> user)
//   wen/waddr/wdata/wbe : write request with per-lane enables (user -> RAM)
//   ren/raddr : read request (user -> RAM)
//   rdata/rvalid : read result and its one-cycle valid (RAM -> user)
// Parameters must match those given to bram_sdp.
interface bram_sdp_if #(
  parameter int Depth     = 512,
  parameter int Width     = 36,
  parameter int ByteWidth = 8
) ();
  localparam int AW       = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int NumLanes = (Width + ByteWidth - 1) / ByteWidth;

  logic                init_busy;
  logic                wen;
  logic [AW-1:0]       waddr;
  logic [Width-1:0]    wdata;
  logic [NumLanes-1:0] wbe;
  logic                ren;
  logic [AW-1:0]       raddr;
  logic [Width-1:0]    rdata;
  logic                rvalid;

  modport master (
    input  init_busy, rdata, rvalid,
    output wen, waddr, wdata, wbe, ren, raddr
  );

  modport slave (
    output init_busy, rdata, rvalid,
    input  wen, waddr, wdata, wbe, ren, raddr
  );
endinterface

// File: rtl/bram_sdp.sv
// bram_sdp: simple-dual-port block RAM, single clock.
//   clk   : clock, all logic on the rising edge
//   rst_n : synchronous active-low reset (control state only, not the array)
//   bus   : bram_sdp_if.slave - write port with per-lane enables, read port
//           with 1- or 2-cycle latency and rvalid, init_busy while the
//           post-reset clear sequencer zeroes the array.
// Same-address read/write collisions return the old word (READ_FIRST) or
// the lane-merged new word (WRITE_FIRST). Out-of-range writes are dropped;
// out-of-range reads return zero with a normal rvalid.
module bram_sdp #(
  parameter int    Depth        = 512,
  parameter int    Width        = 36,
  parameter int    ByteWidth    = 8,
  parameter int    ReadLatency  = 1,
  parameter string WriteMode    = "READ_FIRST",
  parameter int    ClearOnReset = 1
) (
  input logic       clk,
  input logic       rst_n,
  bram_sdp_if.slave bus
);

  localparam int            AW         = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int            NumLanes   = (Width + ByteWidth - 1) / ByteWidth;
  localparam bit            WriteFirst = (WriteMode == "WRITE_FIRST");
  localparam logic [AW:0]   DepthC     = (AW+1)'(Depth);
  localparam logic [AW-1:0] LastAddr   = AW'(Depth - 1);

  typedef enum logic {ST_CLEAR, ST_RUN} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          busy;

  assign busy          = (state_q == ST_CLEAR);
  assign bus.init_busy = busy;

  // Clear sequencer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= (ClearOnReset != 0) ? ST_CLEAR : ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_CLEAR) begin
      cnt_d = cnt_q + AW'(1);
      if (cnt_q == LastAddr) begin
        state_d = ST_RUN;
        cnt_d   = '0;
      end
    end
  end

  // Lane enables expanded to bit masks (last lane may be partial)
  logic [NumLanes-1:0] cbe_q;
  logic [Width-1:0]    wbe_mask, cbe_mask;

  for (genvar l = 0; l < NumLanes; l++) begin : g_lane
    localparam int Lo = l * ByteWidth;
    localparam int Hi = ((l + 1) * ByteWidth > Width) ? Width - 1 : (l + 1) * ByteWidth - 1;
    assign wbe_mask[Hi:Lo] = {(Hi - Lo + 1){bus.wbe[l]}};
    assign cbe_mask[Hi:Lo] = {(Hi - Lo + 1){cbe_q[l]}};
  end

  logic waddr_ok, raddr_ok;
  assign waddr_ok = ({1'b0, bus.waddr} < DepthC);
  assign raddr_ok = ({1'b0, bus.raddr} < DepthC);

  // Single write port shared by the clear sequencer and the user
  logic             we;
  logic [AW-1:0]    wa;
  logic [Width-1:0] wd, wm;

  always_comb begin
    we = 1'b0;
    wa = bus.waddr;
    wd = bus.wdata;
    wm = wbe_mask;
    if (busy) begin
      we = rst_n;
      wa = cnt_q;
      wd = '0;
      wm = '1;
    end else begin
      we = rst_n & bus.wen & waddr_ok;
    end
  end

  logic [Width-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned b = 0; b < Width; b++) begin
        if (wm[b]) mem[wa][b] <= wd[b];
      end
    end
  end

  // Read stage 1: array output plus collision capture (no reset, RAM-friendly)
  logic             rd_fire, col;
  logic [Width-1:0] mem_q, cwd_q, s1;
  logic             col_q, v1_q, zero_q;

  assign rd_fire = rst_n & ~busy & bus.ren;
  assign col     = bus.wen & waddr_ok & raddr_ok & (bus.waddr == bus.raddr);

  always_ff @(posedge clk) begin
    if (rd_fire) begin
      if (raddr_ok) mem_q <= mem[bus.raddr];
      col_q <= col;
      cwd_q <= bus.wdata;
      cbe_q <= bus.wbe;
    end
  end

  // zero_q resets to 1 so the unreset array register reads as zero after
  // reset; it also forces zero for out-of-range reads. All stage-1 state
  // only moves on accepted reads, so rdata holds between results.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v1_q   <= 1'b0;
      zero_q <= 1'b1;
    end else begin
      v1_q <= rd_fire;
      if (rd_fire) zero_q <= ~raddr_ok;
    end
  end

  always_comb begin
    s1 = mem_q;
    if (zero_q) begin
      s1 = '0;
    end else if (WriteFirst && col_q) begin
      s1 = (cbe_mask & cwd_q) | (~cbe_mask & mem_q);
    end
  end

  if (ReadLatency == 2) begin : g_rl2
    logic [Width-1:0] rdata_q;
    logic             v2_q;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        rdata_q <= '0;
        v2_q    <= 1'b0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) rdata_q <= s1;
      end
    end

    assign bus.rdata  = rdata_q;
    assign bus.rvalid = v2_q;
  end else begin : g_rl1
    assign bus.rdata  = s1;
    assign bus.rvalid = v1_q;
  end

endmodule

// File: tb/tb_bram_sdp.sv
// tb_bram_sdp: directed bench for bram_sdp. Five instances share one stimulus:
//   a: Depth16 READ_FIRST RL1 clear   b: as a, WRITE_FIRST
//   c: as a, ReadLatency 2            d: Depth12
//   e: as a, ClearOnReset 0
module tb_bram_sdp;
  logic        clk;
  logic        rst_n;
  logic        wen, ren;
  logic [3:0]  waddr, raddr;
  logic [35:0] wdata;
  logic [4:0]  wbe;

  int n_chk  = 0;
  int n_pass = 0;

  bram_sdp_if #(.Depth(16), .Width(36), .ByteWidth(8)) if_a ();
  bram_sdp_if #(.Depth(16), .Width(36), .ByteWidth(8)) if_b ();
  bram_sdp_if #(.Depth(16), .Width(36), .ByteWidth(8)) if_c ();
  bram_sdp_if #(.Depth(12), .Width(36), .ByteWidth(8)) if_d ();
  bram_sdp_if #(.Depth(16), .Width(36), .ByteWidth(8)) if_e ();

  assign {if_a.wen, if_a.waddr, if_a.wdata, if_a.wbe, if_a.ren, if_a.raddr} = {wen, waddr, wdata, wbe, ren, raddr};
  assign {if_b.wen, if_b.waddr, if_b.wdata, if_b.wbe, if_b.ren, if_b.raddr} = {wen, waddr, wdata, wbe, ren, raddr};
  assign {if_c.wen, if_c.waddr, if_c.wdata, if_c.wbe, if_c.ren, if_c.raddr} = {wen, waddr, wdata, wbe, ren, raddr};
  assign {if_d.wen, if_d.waddr, if_d.wdata, if_d.wbe, if_d.ren, if_d.raddr} = {wen, waddr, wdata, wbe, ren, raddr};
  assign {if_e.wen, if_e.waddr, if_e.wdata, if_e.wbe, if_e.ren, if_e.raddr} = {wen, waddr, wdata, wbe, ren, raddr};

  bram_sdp #(.Depth(16), .Width(36), .ByteWidth(8), .ReadLatency(1),
             .WriteMode("READ_FIRST"), .ClearOnReset(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  bram_sdp #(.Depth(16), .Width(36), .ByteWidth(8), .ReadLatency(1),
             .WriteMode("WRITE_FIRST"), .ClearOnReset(1))
    u_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  bram_sdp #(.Depth(16), .Width(36), .ByteWidth(8), .ReadLatency(2),
             .WriteMode("READ_FIRST"), .ClearOnReset(1))
    u_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  bram_sdp #(.Depth(12), .Width(36), .ByteWidth(8), .ReadLatency(1),
             .WriteMode("READ_FIRST"), .ClearOnReset(1))
    u_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));
  bram_sdp #(.Depth(16), .Width(36), .ByteWidth(8), .ReadLatency(1),
             .WriteMode("READ_FIRST"), .ClearOnReset(0))
    u_e (.clk(clk), .rst_n(rst_n), .bus(if_e.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [35:0] d, input logic [4:0] be);
    wen = 1'b1; waddr = a; wdata = d; wbe = be;
    cyc();
    wen = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    ren = 1'b1; raddr = a;
    cyc();
    ren = 1'b0;
  endtask

  task automatic coll(input logic [3:0] a, input logic [35:0] d, input logic [4:0] be);
    wen = 1'b1; waddr = a; wdata = d; wbe = be;
    ren = 1'b1; raddr = a;
    cyc();
    wen = 1'b0; ren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int nb_a, nb_d, nb_e, nrv;
    rst_n = 1'b0; wen = 1'b0; ren = 1'b0;
    waddr = '0; raddr = '0; wdata = '0; wbe = '0;
    repeat (3) cyc();

    // Reset state
    check("rst_busy_a", 64'(if_a.init_busy), 64'd1);
    check("rst_busy_e", 64'(if_e.init_busy), 64'd0);
    check("rst_out_a", {if_a.rvalid, if_a.rdata}, 64'd0);
    check("rst_out_c", {if_c.rvalid, if_c.rdata}, 64'd0);
    check("rst_out_e", {if_e.rvalid, if_e.rdata}, 64'd0);

    // Clear after reset: busy length per depth, no rvalid
    rst_n = 1'b1;
    nb_a = 0; nb_d = 0; nb_e = 0; nrv = 0;
    for (int k = 0; k < 20; k++) begin
      nb_a += int'(if_a.init_busy);
      nb_d += int'(if_d.init_busy);
      nb_e += int'(if_e.init_busy);
      nrv  += int'(if_a.rvalid) + int'(if_d.rvalid);
      cyc();
    end
    check("clr_len_a", 64'(nb_a), 64'd16);
    check("clr_len_d", 64'(nb_d), 64'd12);
    check("clr_len_e", 64'(nb_e), 64'd0);
    check("clr_rvalid", 64'(nrv), 64'd0);
    for (int i = 0; i < 16; i++) begin
      rd(4'(i));
      check($sformatf("clr_rd%0d", i), {if_a.rvalid, if_a.rdata}, {1'b1, 36'h0});
    end
    cyc();
    check("clr_idle", 64'(if_a.rvalid), 64'd0);

    // Byte enables
    wr(4'd5, 36'h9_8765_4321, 5'b11111);
    wr(4'd5, 36'h0_0000_AB00, 5'b00010);
    rd(4'd5);
    check("be_lane1", {if_a.rvalid, if_a.rdata}, {1'b1, 36'h9_8765_AB21});
    wr(4'd5, 36'hF_0000_0000, 5'b10000);
    rd(4'd5);
    check("be_lane4", {if_a.rvalid, if_a.rdata}, {1'b1, 36'hF_8765_AB21});
    wr(4'd5, 36'hF_FFFF_FFFF, 5'b00000);
    rd(4'd5);
    check("be_none", {if_a.rvalid, if_a.rdata}, {1'b1, 36'hF_8765_AB21});

    // Collisions
    wr(4'd3, 36'h1_1111_1111, 5'b11111);
    coll(4'd3, 36'h2_2222_2222, 5'b11111);
    check("col_rf", {if_a.rvalid, if_a.rdata}, {1'b1, 36'h1_1111_1111});
    check("col_wf", {if_b.rvalid, if_b.rdata}, {1'b1, 36'h2_2222_2222});
    rd(4'd3);
    check("col_after_rf", if_a.rdata, 36'h2_2222_2222);
    check("col_after_wf", if_b.rdata, 36'h2_2222_2222);
    wr(4'd3, 36'h1_1111_1111, 5'b11111);
    coll(4'd3, 36'h2_2222_2222, 5'b00001);
    check("col_wf_lane", {if_b.rvalid, if_b.rdata}, {1'b1, 36'h1_1111_1122});
    check("col_rf_lane", {if_a.rvalid, if_a.rdata}, {1'b1, 36'h1_1111_1111});
    rd(4'd3);
    check("col_lane_after", if_a.rdata, 36'h1_1111_1122);

    // Independent write and read in the same cycle
    wen = 1'b1; waddr = 4'd6; wdata = 36'h0_0000_0077; wbe = 5'b11111;
    ren = 1'b1; raddr = 4'd5;
    cyc();
    wen = 1'b0; ren = 1'b0;
    check("indep_rd", {if_a.rvalid, if_a.rdata}, {1'b1, 36'hF_8765_AB21});
    rd(4'd6);
    check("indep_wr", if_a.rdata, 36'h0_0000_0077);
    cyc();
    check("hold", {if_a.rvalid, if_a.rdata}, {1'b0, 36'h0_0000_0077});

    // Pipelined reads, ReadLatency 2
    for (int i = 0; i < 4; i++) wr(4'(i), 36'(10 + i), 5'b11111);
    cyc();
    for (int k = 0; k < 7; k++) begin
      ren = (k < 4); raddr = 4'(k);
      cyc();
      if (k == 0)     check("rl2_k0", 64'(if_c.rvalid), 64'd0);
      else if (k < 5) check($sformatf("rl2_k%0d", k), {if_c.rvalid, if_c.rdata}, {1'b1, 36'(9 + k)});
      else            check($sformatf("rl2_k%0d", k), {if_c.rvalid, if_c.rdata}, {1'b0, 36'd13});
    end
    ren = 1'b0;

    // Reset mid-clear with requests held during busy
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    wen = 1'b1; waddr = 4'd0; wdata = '1; wbe = 5'b11111;
    ren = 1'b1; raddr = 4'd0;
    nrv = 0;
    for (int k = 0; k < 7; k++) begin
      nrv += int'(if_a.rvalid);
      cyc();
    end
    check("mid_busy", 64'(if_a.init_busy), 64'd1);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    nb_a = 0;
    for (int k = 0; k < 20; k++) begin
      wen = (k < 16); ren = (k < 16);
      nb_a += int'(if_a.init_busy);
      nrv  += int'(if_a.rvalid);
      cyc();
    end
    check("mid_len", 64'(nb_a), 64'd16);
    check("mid_rvalid", 64'(nrv), 64'd0);
    wr(4'd7, 36'h0_0000_003C, 5'b11111);
    rd(4'd7);
    check("mid_rd7", {if_a.rvalid, if_a.rdata}, {1'b1, 36'h0_0000_003C});
    rd(4'd0);
    check("mid_rd0", {if_a.rvalid, if_a.rdata}, {1'b1, 36'h0});
    rd(4'd7);
    rd(4'd3);
    check("mid_rd3", {if_a.rvalid, if_a.rdata}, {1'b1, 36'h0});

    // Out of range on Depth 12
    wr(4'd13, 36'h0_0000_0005, 5'b11111);
    wr(4'd4, 36'hA_BCDE_F012, 5'b11111);
    rd(4'd4);
    check("oor_rd4", {if_d.rvalid, if_d.rdata}, {1'b1, 36'hA_BCDE_F012});
    rd(4'd13);
    check("oor_rd13_d", {if_d.rvalid, if_d.rdata}, {1'b1, 36'h0});
    check("oor_rd13_a", {if_a.rvalid, if_a.rdata}, {1'b1, 36'h0_0000_0005});
    rd(4'd11);
    check("oor_rd11_d", {if_d.rvalid, if_d.rdata}, {1'b1, 36'h0});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/bram_sdp.md
Name: bram_sdp

Overview:
Parametrised simple-dual-port block RAM: one write port and one read port, both on a single clock. It adds the following over the single-port RAM wrapper:
- per-byte write enables;
- selectable read latency of 1 or 2 cycles;
- a read valid pipeline;
- defined read-during-write collision semantics;
- an optional hardware clear sequencer after reset.

It is the storage primitive for CAM tables, which need concurrent lookup-read and update-write.

Parameters:
Depth, 512, number of words; need not be a power of 2.
Width, 36, word width in bits.
ByteWidth, 8, bits per write-enable lane. NumLanes = ceil(Width/ByteWidth); the last lane may be partial.
ReadLatency, 1, cycles from accepted ren to rvalid. Legal values: 1 or 2.
WriteMode, "READ_FIRST", same-address collision result. "READ_FIRST" returns the old word; "WRITE_FIRST" returns the merged new word.
ClearOnReset, 1, 1 = zero all words after reset; 0 = no clear.

Ports:
clk  in  1  clock; all logic on rising edge
rst_n  in  1  reset, synchronous, active-low
init_busy  out  1  clear sequencer running; user ports ignored while high
wen  in  1  write request
waddr  in  $clog2(Depth)  write address
wdata  in  Width  write data
wbe  in  NumLanes  per-lane write enable; lane i = bits [min((i+1)*ByteWidth,Width)-1 : i*ByteWidth]
ren  in  1  read request
raddr  in  $clog2(Depth)  read address
rdata  out  Width  read data
rvalid  out  1  rdata valid, one-cycle pulse per accepted read

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - rvalid=0, rdata=0, clear counter=0, pipeline valids cleared.
  - State = CLEAR if ClearOnReset=1, else RUN.
  - init_busy=1 if ClearOnReset=1, else 0.
  - Memory contents are not reset by rst_n itself.
- FSM states: CLEAR, RUN.
  - CLEAR: each cycle writes all-zero to address cnt, then cnt++.
  - When cnt=Depth-1 is written, transition to RUN; init_busy=0 from the next cycle.
  - Exactly Depth cycles with init_busy=1 after rst_n rises.
  - Reset asserted mid-CLEAR restarts the sequence at address 0.
- While init_busy=1:
  - wen and ren are ignored.
  - No rvalid is generated.
- Write (RUN, wen=1, waddr<Depth):
  - Lanes with wbe[i]=1 are updated at the clock edge.
  - Lanes with wbe[i]=0 are unchanged.
  - wbe=0 is a no-op.
- Read (RUN, ren=1):
  - ReadLatency=1: rvalid=1 and rdata valid on the cycle after the ren edge.
  - ReadLatency=2: the array output is registered once more, giving rvalid 2 cycles after ren.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
  - rdata holds its last value when rvalid=0.
- Out of range (address >= Depth):
  - A write is dropped.
  - A read returns rdata=0 with rvalid=1 at normal latency.
- Collision (wen & ren, waddr==raddr, both in range, same cycle):
  - READ_FIRST: rdata = pre-write word.
  - WRITE_FIRST: rdata = per-lane merge of wdata (wbe=1 lanes) and the old word (wbe=0 lanes).
  - Implementation: register the collision flag, wdata and wbe; merge at the array output stage.
  - Any later read returns the new word in both modes.
- Writes and reads to different addresses in the same cycle are independent.
- Storage is inferred as block RAM; no vendor primitives.

Test Plan:
Common configuration: Depth=16, Width=36, ByteWidth=8 (NumLanes=5), ReadLatency=1, WriteMode=READ_FIRST, ClearOnReset=1 unless stated.

1. Clear after reset:
   - Stimulus: release rst_n, then read 0..15 after init_busy falls.
   - Required: init_busy high for exactly 16 cycles; all 16 reads return 36'h0 with rvalid.
2. Byte enables:
   - Stimulus: write addr 5 = 36'h9_8765_4321 (wbe=5'b11111); then write addr 5 = 36'h0_0000_AB00 with wbe=5'b00010; read 5.
   - Required: rdata = 36'h9_8765_AB21.
   - Stimulus: then write 36'hF_0000_0000 with wbe=5'b10000; read 5.
   - Required: rdata = 36'hF_8765_AB21.
3. Collision:
   - Stimulus: addr 3 = 36'h1_1111_1111; same cycle write 36'h2_2222_2222 (wbe all 1) and read addr 3.
   - Required: READ_FIRST returns 36'h1_1111_1111; WRITE_FIRST returns 36'h2_2222_2222; the following read returns 36'h2_2222_2222 in both modes.
   - Stimulus: WRITE_FIRST with wbe=5'b00001.
   - Required: rdata = 36'h1_1111_1122.
4. Latency and pipelining (ReadLatency=2):
   - Stimulus: ren on cycles n..n+3 for addrs 0..3 holding 10,11,12,13; then ren=0.
   - Required: rvalid high on n+2..n+5 with data 10,11,12,13; then rvalid=0 and rdata holds 13.
5. Reset mid-clear:
   - Stimulus: pull rst_n low for 1 cycle at clear cycle 7; assert ren and wen during busy.
   - Required: init_busy stays high for 16 cycles after the second release; no rvalid; no write lands.
6. Out of range (Depth=12):
   - Stimulus: write addr 13 = 36'h5; read addr 13; read addr 11.
   - Required: read 13 returns 0 with rvalid=1; read 11 returns 0 (cleared value, unaffected by the dropped write).
